// File: rtl/core_idq_pkg.sv
// i2d_core_defines: shared core types, instruction layout, opcodes and the decode-queue entry.
package i2d_core_defines;
  typedef logic [31:0] addr_t;
  typedef logic [3:0] reg_addr_t;
  typedef logic [2:0] flag_t;
  localparam reg_addr_t RF_PC = 4'hF;
  typedef enum logic [5:0] {
    OPCODE_NOP, OPCODE_ADD, OPCODE_SUB, OPCODE_MOV, OPCODE_B, OPCODE_CALL,
    OPCODE_RET, OPCODE_SWI, OPCODE_RFE, OPCODE_LD, OPCODE_ST
  } opcode_t;
  typedef enum logic [1:0] {OPMUX_A_RA, OPMUX_A_PC, OPMUX_A_WB} opmux_a_t;
  typedef enum logic [1:0] {OPMUX_B_RB, OPMUX_B_PC, OPMUX_B_WB, OPMUX_B_IMM} opmux_b_t;
  // opcode is left raw so illegal encodings survive the trip through the queue
  typedef struct packed {
    logic [5:0] opcode;
    reg_addr_t  regd_cond;
    reg_addr_t  rega;
    reg_addr_t  regb;
    logic       i;
    logic       s;
    logic [11:0] imm;
  } instr_t;
  typedef struct packed {
    addr_t  pc;
    instr_t instr;
  } idq_entry_t;
  localparam logic [25:0] IDQ_FLUSH_MARK = 26'(1);
  function automatic logic op_legal(logic [5:0] op);
    return op <= 6'(OPCODE_ST);
  endfunction
endpackage

// File: rtl/core_idq_fifo.sv
// core_idq_fifo: circular buffer of idq_entry_t; flush wins over push and pop.
module core_idq_fifo
  import i2d_core_defines::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      flush,
  input  idq_entry_t                din,
  output idq_entry_t                head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(QDEPTH);
  idq_entry_t mem [QDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(QDEPTH);
  assign empty = count == '0;
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/core_idq.sv
// core_idq: queued instruction-decode stage; CORE_IDQ_ILLEGAL_EN enables registered illegal-opcode detection.
module core_idq
  import i2d_core_defines::*;
#(
  parameter int QDEPTH   = 4,
  parameter int DATA_W   = 32,
  parameter int IMM_BITS = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_valid,
  output logic                     if_ready,
  input  addr_t                    if_pc,
  input  instr_t                   if_instr,
  input  logic                     id_halt,
  input  logic                     id_flush,
  input  logic                     wb_valid,
  input  reg_addr_t                wb_addr,
  input  flag_t                    flag,
  output reg_addr_t                rega_addr,
  output reg_addr_t                regb_addr,
  output logic                     id_valid,
  output addr_t                    id_pc,
  output instr_t                   id_instr,
  output logic [DATA_W-1:0]        imm,
  output opmux_a_t                 opmux_a,
  output opmux_b_t                 opmux_b,
  output logic                     branch,
  output logic                     branch_imm,
  output logic                     branch_abs,
  output logic                     swi,
  output logic                     rfe,
  output logic                     wb_spr,
  output reg_addr_t                spr_addr,
  output logic                     id_err,
  output logic [$clog2(QDEPTH):0]  q_count
);
  idq_entry_t head;
  logic full, empty, load;
  core_idq_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(if_valid), .pop(load), .flush(id_flush),
    .din('{pc: if_pc, instr: if_instr}), .head(head), .count(q_count),
    .full(full), .empty(empty)
  );
  assign if_ready = !full;
  assign load = !id_flush && !id_halt && !empty;
  assign rega_addr = empty ? '0 : head.instr.rega;
  assign regb_addr = empty ? '0 : head.instr.regb;
  function automatic logic [DATA_W-1:0] ext_imm(instr_t x);
    return !x.i ? '0 : x.s ? {{(DATA_W-IMM_BITS){x[IMM_BITS-1]}}, x[IMM_BITS-1:0]}
                           : {{(DATA_W-IMM_BITS){1'b0}}, x[IMM_BITS-1:0]};
  endfunction
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid <= 1'b0;
      id_pc <= '0;
      id_instr <= {OPCODE_NOP, 26'(0)};
      imm <= '0;
      swi <= 1'b0;
    end else if (id_flush) begin
      id_valid <= 1'b0;
      id_instr <= {OPCODE_NOP, IDQ_FLUSH_MARK};
      imm <= '0;
      swi <= 1'b0;
    end else if (!id_halt) begin
      id_valid <= !empty;
      id_pc <= empty ? id_pc : head.pc;
      id_instr <= empty ? {OPCODE_NOP, 26'(0)} : head.instr;
      imm <= empty ? '0 : ext_imm(head.instr);
      swi <= !empty && head.instr.opcode == OPCODE_SWI;
    end
  end
`ifdef CORE_IDQ_ILLEGAL_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) id_err <= 1'b0;
    else if (id_flush) id_err <= 1'b0;
    else if (!id_halt) id_err <= !empty && !op_legal(head.instr.opcode);
  end
`else
  assign id_err = 1'b0;
`endif
  assign opmux_a = id_instr.rega == RF_PC ? OPMUX_A_PC :
                   (wb_valid && id_instr.rega == wb_addr) ? OPMUX_A_WB : OPMUX_A_RA;
  assign opmux_b = id_instr.i ? OPMUX_B_IMM : id_instr.regb == RF_PC ? OPMUX_B_PC :
                   (wb_valid && id_instr.regb == wb_addr) ? OPMUX_B_WB : OPMUX_B_RB;
  assign branch = id_valid && (id_instr.opcode == OPCODE_B ? id_instr.regd_cond[2:0] == flag :
                  id_instr.opcode == OPCODE_CALL || id_instr.opcode == OPCODE_RET);
  assign branch_imm = id_instr.i;
  assign branch_abs = id_instr.regb[0];
  assign rfe = id_valid && id_instr.opcode == OPCODE_RFE;
  assign wb_spr = id_valid && id_instr.opcode == OPCODE_MOV && id_instr.regb[1];
  assign spr_addr = id_instr.regd_cond;
endmodule

// File: tb/tb_core_idq.sv
// tb_core_idq: directed self-checking bench for core_idq (QDEPTH=4, DATA_W=32, IMM_BITS=11).
module tb_core_idq;
  import i2d_core_defines::*;
  logic clk = 1'b0, rst = 1'b0;
  logic if_valid = 1'b0, id_halt = 1'b0, id_flush = 1'b0, wb_valid = 1'b0;
  addr_t if_pc = '0;
  instr_t if_instr = '0;
  reg_addr_t wb_addr = '0;
  flag_t flag = '0;
  logic if_ready, id_valid, branch, branch_imm, branch_abs, swi, rfe, wb_spr, id_err;
  reg_addr_t rega_addr, regb_addr, spr_addr;
  addr_t id_pc;
  instr_t id_instr;
  logic [31:0] imm;
  opmux_a_t opmux_a;
  opmux_b_t opmux_b;
  logic [2:0] q_count;
  int vectors = 0, errors = 0;

  core_idq #(.QDEPTH(4), .DATA_W(32), .IMM_BITS(11)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .id_halt(id_halt), .id_flush(id_flush), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .flag(flag), .rega_addr(rega_addr), .regb_addr(regb_addr),
    .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr), .imm(imm),
    .opmux_a(opmux_a), .opmux_b(opmux_b), .branch(branch), .branch_imm(branch_imm),
    .branch_abs(branch_abs), .swi(swi), .rfe(rfe), .wb_spr(wb_spr), .spr_addr(spr_addr),
    .id_err(id_err), .q_count(q_count)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  function automatic instr_t mk(logic [5:0] op, logic [3:0] rd, logic [3:0] ra, logic [3:0] rb,
                                logic i, logic s, logic [11:0] im);
    instr_t x;
    x.opcode = op; x.regd_cond = rd; x.rega = ra; x.regb = rb; x.i = i; x.s = s; x.imm = im;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_load(input addr_t pc, input instr_t ins);
    if_valid = 1'b1; if_pc = pc; if_instr = ins;
    tick();
    if_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #2;
    vectors++; if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", q_count); end
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", id_valid); end
    vectors++; if (id_instr !== instr_t'(32'h0)) begin errors++; $display("FAIL reset_instr got %h want 0", id_instr); end
    vectors++; if (imm !== 32'h0 || swi !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL reset_regs imm %h swi %b pc %h want 0", imm, swi, id_pc); end
    vectors++; if (if_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", if_ready); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    instr_t add = mk(OPCODE_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 12'h0);
    if_valid = 1'b1; if_pc = 32'h100; if_instr = add;
    tick();
    if_valid = 1'b0;
    vectors++; if (q_count !== 3'd1 || id_valid !== 1'b0) begin errors++; $display("FAIL basic_push count %0d valid %b want 1/0", q_count, id_valid); end
    tick();
    vectors++; if (id_valid !== 1'b1 || id_pc !== 32'h100) begin errors++; $display("FAIL basic_load valid %b pc %h want 1/100", id_valid, id_pc); end
    vectors++; if (q_count !== 3'd0 || id_instr !== add) begin errors++; $display("FAIL basic_pop count %0d instr %h want 0/%h", q_count, id_instr, add); end
    tick();
    vectors++; if (id_valid !== 1'b0 || id_instr !== instr_t'(32'h0)) begin errors++; $display("FAIL basic_empty valid %b instr %h want 0/0", id_valid, id_instr); end
  endtask

  task automatic test_back_to_back();
    id_halt = 1'b1; if_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if_pc = 32'h200 + 32'(4*k);
      if_instr = mk(OPCODE_SUB, 4'(k), 4'd1, 4'd2, 1'b0, 1'b0, 12'h0);
      vectors++; if (if_ready !== (k < 4)) begin errors++; $display("FAIL full_ready k=%0d got %b want %b", k, if_ready, k < 4); end
      tick();
    end
    if_valid = 1'b0;
    vectors++; if (q_count !== 3'd4 || id_valid !== 1'b0) begin errors++; $display("FAIL full_count count %0d valid %b want 4/0", q_count, id_valid); end
    id_halt = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if (id_valid !== 1'b1 || id_pc !== 32'h200 + 32'(4*k) || q_count !== 3'(3-k)) begin
        errors++; $display("FAIL drain k=%0d valid %b pc %h count %0d want 1/%h/%0d", k, id_valid, id_pc, q_count, 32'h200 + 32'(4*k), 3-k);
      end
    end
    tick();
    vectors++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drain_fifth got valid %b want 0", id_valid); end
  endtask

  task automatic test_imm();
    push_load(32'h300, mk(OPCODE_ADD, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 12'h7FF));
    vectors++; if (imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL imm_sext got %h want ffffffff", imm); end
    vectors++; if (opmux_b !== OPMUX_B_IMM || branch_imm !== 1'b1) begin errors++; $display("FAIL imm_mux got %0d/%b want %0d/1", opmux_b, branch_imm, OPMUX_B_IMM); end
    push_load(32'h304, mk(OPCODE_ADD, 4'd1, 4'd2, 4'd0, 1'b1, 1'b0, 12'h7FF));
    vectors++; if (imm !== 32'h0000_07FF) begin errors++; $display("FAIL imm_zext got %h want 000007ff", imm); end
    push_load(32'h308, mk(OPCODE_ADD, 4'd1, 4'd2, 4'd0, 1'b1, 1'b1, 12'h3FF));
    vectors++; if (imm !== 32'h0000_03FF) begin errors++; $display("FAIL imm_pos got %h want 000003ff", imm); end
  endtask

  task automatic test_flush();
    id_halt = 1'b1; if_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if_pc = 32'h400 + 32'(4*k);
      if_instr = mk(OPCODE_CALL, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0, 12'h0);
      tick();
    end
    vectors++; if (q_count !== 3'd3) begin errors++; $display("FAIL flush_fill got %0d want 3", q_count); end
    id_flush = 1'b1; if_pc = 32'h40C;
    tick();
    id_flush = 1'b0; if_valid = 1'b0; id_halt = 1'b0;
    vectors++; if (q_count !== 3'd0) begin errors++; $display("FAIL flush_count got %0d want 0", q_count); end
    vectors++; if (id_instr !== instr_t'(32'h1) || id_valid !== 1'b0) begin errors++; $display("FAIL flush_mark instr %h valid %b want 1/0", id_instr, id_valid); end
    vectors++; if (branch !== 1'b0 || id_pc !== 32'h308) begin errors++; $display("FAIL flush_hold branch %b pc %h want 0/308", branch, id_pc); end
    tick();
    vectors++; if (q_count !== 3'd0 || id_valid !== 1'b0) begin errors++; $display("FAIL flush_after count %0d valid %b want 0/0", q_count, id_valid); end
  endtask

  task automatic test_branch();
    push_load(32'h500, mk(OPCODE_B, 4'b0010, 4'd1, 4'd1, 1'b0, 1'b0, 12'h0));
    flag = 3'b010; #1;
    vectors++; if (branch !== 1'b1 || branch_abs !== 1'b1) begin errors++; $display("FAIL b_taken branch %b abs %b want 1/1", branch, branch_abs); end
    flag = 3'b001; #1;
    vectors++; if (branch !== 1'b0) begin errors++; $display("FAIL b_not_taken got %b want 0", branch); end
    push_load(32'h504, mk(OPCODE_CALL, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 12'h0));
    flag = 3'b000; #1;
    vectors++; if (branch !== 1'b1) begin errors++; $display("FAIL call_f0 got %b want 1", branch); end
    flag = 3'b111; #1;
    vectors++; if (branch !== 1'b1 || branch_abs !== 1'b0) begin errors++; $display("FAIL call_f7 branch %b abs %b want 1/0", branch, branch_abs); end
    push_load(32'h508, mk(OPCODE_SWI, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 12'h0));
    vectors++; if (swi !== 1'b1 || branch !== 1'b0) begin errors++; $display("FAIL swi swi %b branch %b want 1/0", swi, branch); end
    push_load(32'h50C, mk(OPCODE_RFE, 4'd0, 4'd1, 4'd0, 1'b0, 1'b0, 12'h0));
    vectors++; if (rfe !== 1'b1 || swi !== 1'b0) begin errors++; $display("FAIL rfe rfe %b swi %b want 1/0", rfe, swi); end
    push_load(32'h510, mk(OPCODE_MOV, 4'd9, 4'd1, 4'd2, 1'b0, 1'b0, 12'h0));
    vectors++; if (wb_spr !== 1'b1 || spr_addr !== 4'd9 || rfe !== 1'b0) begin errors++; $display("FAIL mov_spr wb_spr %b spr %0d rfe %b want 1/9/0", wb_spr, spr_addr, rfe); end
    tick();
    vectors++; if (wb_spr !== 1'b0 || branch !== 1'b0) begin errors++; $display("FAIL idle_ctrl wb_spr %b branch %b want 0/0", wb_spr, branch); end
  endtask

  task automatic test_opmux();
    if_valid = 1'b1; if_pc = 32'h600; if_instr = mk(OPCODE_ADD, 4'd1, 4'd3, 4'd5, 1'b0, 1'b0, 12'h0);
    tick();
    if_valid = 1'b0;
    vectors++; if (rega_addr !== 4'd3 || regb_addr !== 4'd5) begin errors++; $display("FAIL head_regs ra %0d rb %0d want 3/5", rega_addr, regb_addr); end
    tick();
    vectors++; if (rega_addr !== 4'd0 || regb_addr !== 4'd0) begin errors++; $display("FAIL head_empty ra %0d rb %0d want 0/0", rega_addr, regb_addr); end
    wb_valid = 1'b1; wb_addr = 4'd5; #1;
    vectors++; if (opmux_b !== OPMUX_B_WB || opmux_a !== OPMUX_A_RA) begin errors++; $display("FAIL fwd_b a %0d b %0d want %0d/%0d", opmux_a, opmux_b, OPMUX_A_RA, OPMUX_B_WB); end
    wb_addr = 4'd3; #1;
    vectors++; if (opmux_a !== OPMUX_A_WB || opmux_b !== OPMUX_B_RB) begin errors++; $display("FAIL fwd_a a %0d b %0d want %0d/%0d", opmux_a, opmux_b, OPMUX_A_WB, OPMUX_B_RB); end
    push_load(32'h604, mk(OPCODE_ADD, 4'd1, RF_PC, 4'd5, 1'b0, 1'b0, 12'h0));
    wb_addr = RF_PC; #1;
    vectors++; if (opmux_a !== OPMUX_A_PC) begin errors++; $display("FAIL pc_prio got %0d want %0d", opmux_a, OPMUX_A_PC); end
    wb_valid = 1'b0; #1;
    vectors++; if (opmux_b !== OPMUX_B_RB) begin errors++; $display("FAIL no_fwd got %0d want %0d", opmux_b, OPMUX_B_RB); end
  endtask

  task automatic test_reset_mid();
    id_halt = 1'b1; if_valid = 1'b1;
    if_pc = 32'h700; if_instr = mk(OPCODE_ADD, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0, 12'h0);
    tick();
    tick();
    if_valid = 1'b0;
    vectors++; if (q_count !== 3'd2) begin errors++; $display("FAIL mid_fill got %0d want 2", q_count); end
    rst = 1'b0; #1;
    vectors++; if (q_count !== 3'd0 || id_valid !== 1'b0 || id_pc !== 32'h0) begin errors++; $display("FAIL mid_reset count %0d valid %b pc %h want 0/0/0", q_count, id_valid, id_pc); end
    rst = 1'b1; id_halt = 1'b0;
    tick();
    vectors++; if (id_valid !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL mid_after valid %b count %0d want 0/0", id_valid, q_count); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_imm();
    test_flush();
    test_branch();
    test_opmux();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
